// File: rtl/bird_pipe_collide_if.sv
// Signal bundle between the motion stages and the collision/score block.
// The master drives bird/pipe positions and start; the slave returns game status.
interface bird_pipe_collide_if;
    logic        start;
    logic [9:0]  BirdX;
    logic [9:0]  BirdY;
    logic [9:0]  BirdS;
    logic [9:0]  PipeX;
    logic [9:0]  PipeGapY;
    logic [1:0]  game_state;
    logic        collide;
    logic [11:0] score_bcd;
    logic [11:0] high_bcd;
    logic        freeze;

    modport master (
        output start, BirdX, BirdY, BirdS, PipeX, PipeGapY,
        input  game_state, collide, score_bcd, high_bcd, freeze
    );

    modport slave (
        input  start, BirdX, BirdY, BirdS, PipeX, PipeGapY,
        output game_state, collide, score_bcd, high_bcd, freeze
    );
endinterface

// File: rtl/bird_pipe_collide.sv
// Per-frame bird/pipe/ground collision test, game-state FSM and BCD score keeping.
// Define HIGH_SCORE_EN to keep a high-score register; otherwise high_bcd reads 000.
module bird_pipe_collide #(
    parameter int PIPE_HW  = 20,
    parameter int GAP_HH   = 50,
    parameter int GROUND_Y = 470,
    parameter int HIT_HOLD = 60
) (
    input  logic                 frame_clk,
    input  logic                 Reset,
    bird_pipe_collide_if.slave   bus
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_PLAY = 2'b01,
        ST_HIT  = 2'b10,
        ST_OVER = 2'b11
    } state_t;

    localparam int CW = (HIT_HOLD > 1) ? $clog2(HIT_HOLD) : 1;
    localparam logic [CW-1:0] HOLD_LAST = CW'(HIT_HOLD - 1);
    localparam logic [10:0]   PW  = 11'(PIPE_HW);
    localparam logic [10:0]   GH  = 11'(GAP_HH);
    localparam logic [10:0]   GND = 11'(GROUND_Y);

    state_t        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [11:0]   score_q, score_d;
    logic          collide_q, collide_d;
    logic          freeze_q, freeze_d;
    logic          start_prev_q;
    logic [9:0]    pipex_prev_q;

    logic [10:0] bx, by, bs, px, gy, ppx;
    logic        start_edge, hx, out_gap, ground, hit, pass_evt;

    function automatic logic [11:0] bcd_inc(input logic [11:0] v);
        logic [3:0] d0, d1, d2;
        d0 = v[3:0];
        d1 = v[7:4];
        d2 = v[11:8];
        if (v == 12'h999) return v;
        if (d0 == 4'd9) begin
            d0 = 4'd0;
            if (d1 == 4'd9) begin
                d1 = 4'd0;
                d2 = d2 + 4'd1;
            end else begin
                d1 = d1 + 4'd1;
            end
        end else begin
            d0 = d0 + 4'd1;
        end
        return {d2, d1, d0};
    endfunction

    // Every compare is arranged with sums on both sides so nothing can wrap.
    always_comb begin
        bx  = {1'b0, bus.BirdX};
        by  = {1'b0, bus.BirdY};
        bs  = {1'b0, bus.BirdS};
        px  = {1'b0, bus.PipeX};
        gy  = {1'b0, bus.PipeGapY};
        ppx = {1'b0, pipex_prev_q};
        start_edge = bus.start & ~start_prev_q;
        hx       = (bx + bs + PW >= px) & (bx <= px + PW + bs);
        out_gap  = (by + bs > gy + GH) | (by + GH < gy + bs);
        ground   = (by + bs >= GND);
        hit      = (hx & out_gap) | ground;
        pass_evt = (ppx + PW >= bx) & (px + PW < bx);
    end

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        score_d   = score_q;
        collide_d = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (start_edge) begin
                    state_d = ST_PLAY;
                    score_d = 12'h000;
                end
            end
            ST_PLAY: begin
                if (hit) begin
                    state_d   = ST_HIT;
                    collide_d = 1'b1;
                    cnt_d     = '0;
                end else if (pass_evt) begin
                    score_d = bcd_inc(score_q);
                end
            end
            ST_HIT: begin
                if (cnt_q == HOLD_LAST) state_d = ST_OVER;
                else                    cnt_d   = cnt_q + 1'b1;
            end
            ST_OVER: begin
                if (start_edge) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
        freeze_d = (state_d != ST_PLAY);
    end

    always_ff @(posedge frame_clk) begin
        if (Reset) begin
            state_q      <= ST_IDLE;
            cnt_q        <= '0;
            score_q      <= 12'h000;
            collide_q    <= 1'b0;
            freeze_q     <= 1'b1;
            start_prev_q <= 1'b0;
            pipex_prev_q <= 10'd0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            score_q      <= score_d;
            collide_q    <= collide_d;
            freeze_q     <= freeze_d;
            start_prev_q <= bus.start;
            pipex_prev_q <= bus.PipeX;
        end
    end

`ifdef HIGH_SCORE_EN
    logic [11:0] high_q, high_d;

    // BCD digits order the same way as binary, so a plain compare suffices.
    always_comb begin
        high_d = high_q;
        if (state_q == ST_HIT && cnt_q == HOLD_LAST && score_q > high_q)
            high_d = score_q;
    end

    always_ff @(posedge frame_clk) begin
        if (Reset) high_q <= 12'h000;
        else       high_q <= high_d;
    end

    assign bus.high_bcd = high_q;
`else
    assign bus.high_bcd = 12'h000;
`endif

    assign bus.game_state = state_q;
    assign bus.collide    = collide_q;
    assign bus.score_bcd  = score_q;
    assign bus.freeze     = freeze_q;

endmodule

// File: doc/bird_pipe_collide.md
Name: bird_pipe_collide

Overview:
- Downstream consumer of the bird position stage (BallX/BallY/BallS) and the pipe position stage.
- Each frame, tests the bird box against one pipe's solid region and the ground, and runs the game-state FSM.
- Counts pipes passed as a 3-digit BCD score, holds a high score, and drives a freeze flag back to the motion stages.

Parameters:
- PIPE_HW, 20: pipe half-width in pixels.
- GAP_HH, 50: half-height of the pipe gap in pixels.
- GROUND_Y, 470: ground line Y; bird bottom at or below this is a hit.
- HIT_HOLD, 60: frames spent in HIT before OVER.

Ports:
- frame_clk  input  1: frame-rate clock; all state updates on its rising edge.
- Reset  input  1: synchronous, active-high reset.
- start  input  1: start/flap request level; only its rising edge is used.
- BirdX  input  10: bird centre X.
- BirdY  input  10: bird centre Y.
- BirdS  input  10: bird half-size.
- PipeX  input  10: pipe centre X.
- PipeGapY  input  10: gap centre Y.
- game_state  output  2: 00 IDLE, 01 PLAY, 10 HIT, 11 OVER.
- collide  output  1: one-frame pulse on the PLAY->HIT transition.
- score_bcd  output  12: current score, 3 BCD digits.
- high_bcd  output  12: high score, 3 BCD digits.
- freeze  output  1: 1 = motion stages hold position.

Behaviour:
- Reset values, all applied synchronously:
  - game_state=IDLE, collide=0, score_bcd=0, high_bcd=0, freeze=1.
  - Hold counter=0, start_d=0, pipex_d=0.
- Reset mid-operation returns every register, including high_bcd, to its reset value on the next edge.
- Latency: inputs sampled at edge k; all outputs registered and valid after edge k.
- start_edge = start & ~start_d.
- pipex_d <= PipeX every frame, in every state.
- Arithmetic: all sums zero-extended to 11 bits. Compares are rearranged so that no subtraction occurs (no wrap):
  - hx (horizontal overlap) = (BirdX+BirdS+PIPE_HW >= PipeX) & (BirdX <= PipeX+PIPE_HW+BirdS).
  - out_gap (bird outside the gap) = (BirdY+BirdS > PipeGapY+GAP_HH) | (BirdY+GAP_HH < PipeGapY+BirdS).
  - ground = (BirdY+BirdS >= GROUND_Y).
  - hit = (hx & out_gap) | ground. The ceiling is not a hit.
- pass event = (pipex_d+PIPE_HW >= BirdX) & (PipeX+PIPE_HW < BirdX).
  - A pipe respawn jump (PipeX > pipex_d) can never satisfy this.
- FSM:
  - IDLE: freeze=1. On start_edge: go to PLAY, clear score_bcd.
  - PLAY: freeze=0.
    - hit: go to HIT, collide=1 for that frame, hold counter=0. Hit has priority over pass in the same frame; the score is not incremented.
    - else pass: score_bcd increments with BCD carry, saturating at 999.
    - start is ignored in PLAY.
  - HIT: freeze=1. Counter increments each frame; when the counter reaches HIT_HOLD-1, go to OVER. If score_bcd > high_bcd, high_bcd <= score_bcd on that same edge.
  - OVER: freeze=1. Score is held. On start_edge: go to IDLE.
- collide is 0 in every frame other than the PLAY->HIT frame.
- Holding start high causes at most one transition.

Optional Feature:
- Macro: HIGH_SCORE_EN.
- Defined: high-score register and update as described above.
- Undefined: no high-score register; high_bcd is tied to 12'h000. All other behaviour is identical.

Test Plan:
- Reset, then start=1 for 3 frames -> game_state 00 to 01 exactly once; freeze 1 to 0; score_bcd=000.
- PLAY with Bird (100,240,4), PipeGapY=240, PipeX stepping 130 down to 70 by 1 per frame -> score_bcd=001 after the frame where PipeX=79 is sampled; collide stays 0.
- PLAY with Bird (100,300,4), PipeGapY=240, PipeX=120 -> collide=1 for one frame and game_state=10; with HIT_HOLD=4, game_state=11 four frames after entering HIT; freeze=1 throughout.
- PLAY with BirdY=466, BirdS=4, PipeX=600 -> ground hit, collide pulse. PipeX jump 5 -> 639 during PLAY -> no score change.
- HIGH_SCORE_EN defined:
  - Game 1 scores 3, then hits -> high_bcd=003 on entry to OVER.
  - start -> IDLE, start -> PLAY, score 1, hit -> high_bcd stays 003.
  - Reset -> high_bcd=000.
- Reset asserted in PLAY with score_bcd=005 -> next frame game_state=00, score_bcd=000, freeze=1, collide=0.
